// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg
//   Shared constants for the execute-stage multiply/divide unit:
//   MDU op encodings (the op port), the R-type funct codes the Control path
//   decodes into start/op/hi_we/lo_we, and the unit's FSM state encoding.
package mult_div_unit_pkg;

    // op port encodings: op[1] selects divide, op[0] selects unsigned
    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    // R-type funct field values handled through this unit
    localparam logic [5:0] FUNCT_MFHI  = 6'd16;
    localparam logic [5:0] FUNCT_MTHI  = 6'd17;
    localparam logic [5:0] FUNCT_MFLO  = 6'd18;
    localparam logic [5:0] FUNCT_MTLO  = 6'd19;
    localparam logic [5:0] FUNCT_MULT  = 6'd24;
    localparam logic [5:0] FUNCT_MULTU = 6'd25;
    localparam logic [5:0] FUNCT_DIV   = 6'd26;
    localparam logic [5:0] FUNCT_DIVU  = 6'd27;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } mdu_state_t;

endpackage

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix
//   Combinational conditional two's-complement negation.
//   wide=1 : {out_hi,out_lo} = neg_hi ? -{in_hi,in_lo} : {in_hi,in_lo}  (2N-bit)
//   wide=0 : each N-bit half is negated independently (neg_hi / neg_lo).
// Ports:
//   wide            select 2N-bit or dual N-bit mode
//   neg_hi, neg_lo  negate controls
//   in_hi, in_lo    N-bit inputs
//   out_hi, out_lo  N-bit results
module mdu_sign_fix #(
    parameter int N = 32
) (
    input  logic         wide,
    input  logic         neg_hi,
    input  logic         neg_lo,
    input  logic [N-1:0] in_hi,
    input  logic [N-1:0] in_lo,
    output logic [N-1:0] out_hi,
    output logic [N-1:0] out_lo
);

    logic [2*N-1:0] joined;
    logic [2*N-1:0] joined_neg;

    assign joined     = {in_hi, in_lo};
    assign joined_neg = -joined;

    always_comb begin
        out_hi = in_hi;
        out_lo = in_lo;
        if (wide) begin
            if (neg_hi) begin
                {out_hi, out_lo} = joined_neg;
            end
        end else begin
            if (neg_hi) out_hi = -in_hi;
            if (neg_lo) out_lo = -in_lo;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Iterative radix-2 multiply/divide unit producing HI/LO. One iteration per
//   clock; done pulses N+1 cycles after the start edge. mthi/mtlo write HI/LO
//   directly while idle.
//   Handshake: start is accepted only on a clock edge where busy=0; the result
//   is valid in hi/lo (and div_by_zero) in the single cycle done=1 and hi/lo
//   hold it afterwards. busy=1 means no new start or hi/lo write is accepted.
// Ports:
//   clock, reset (async, active-low)
//   start, op[1:0], inA, inB     launch mult/multu/div/divu
//   hi_we, lo_we, wdata          mthi/mtlo
//   busy, done, div_by_zero      status
//   hi, lo                       HI/LO registers
module mult_div_unit #(
    parameter int N = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] inA,
    input  logic [N-1:0] inB,
    input  logic         hi_we,
    input  logic         lo_we,
    input  logic [N-1:0] wdata,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);
    import mult_div_unit_pkg::*;

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    mdu_state_t     state, next_state;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   acc;       // MUL: product high half; DIV: remainder
    logic [N-1:0]   low;       // MUL: multiplier/product low; DIV: dividend/quotient
    logic [N-1:0]   opnd;      // MUL: multiplicand magnitude; DIV: divisor magnitude
    logic           is_div, res_sign, div_sign, dbz;

    logic           is_signed, a_neg, b_neg;
    logic           fix_wide, fix_neg_hi, fix_neg_lo;
    logic [N-1:0]   fix_in_hi, fix_in_lo, fix_out_hi, fix_out_lo;

    logic [N:0]     mul_sum;
    logic [N:0]     div_shift, div_diff;

    assign is_signed = ~op[0];
    assign a_neg     = is_signed & inA[N-1];
    assign b_neg     = is_signed & inB[N-1];
    assign busy      = (state != ST_IDLE);

    // FSM next state
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (start) next_state = op[1] ? ST_DIV : ST_MUL;
            ST_MUL,
            ST_DIV:  if (cnt == LAST) next_state = ST_FIX;
            ST_FIX:  next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // The single sign-fix instance takes operand magnitudes while idle and
    // applies the result signs in FIX.
    always_comb begin
        fix_wide   = 1'b0;
        fix_in_hi  = inA;
        fix_in_lo  = inB;
        fix_neg_hi = a_neg;
        fix_neg_lo = b_neg;
        if (state == ST_FIX) begin
            fix_in_hi = acc;
            fix_in_lo = low;
            if (is_div) begin
                fix_neg_hi = div_sign;   // remainder follows the dividend
                fix_neg_lo = res_sign;
            end else begin
                fix_wide   = 1'b1;
                fix_neg_hi = res_sign;
                fix_neg_lo = 1'b0;
            end
        end
    end

    mdu_sign_fix #(.N(N)) u_sign_fix (
        .wide   (fix_wide),
        .neg_hi (fix_neg_hi),
        .neg_lo (fix_neg_lo),
        .in_hi  (fix_in_hi),
        .in_lo  (fix_in_lo),
        .out_hi (fix_out_hi),
        .out_lo (fix_out_lo)
    );

    // One radix-2 step of each algorithm
    assign mul_sum   = {1'b0, acc} + (low[0] ? {1'b0, opnd} : '0);
    assign div_shift = {acc, low[N-1]};
    assign div_diff  = div_shift - {1'b0, opnd};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            acc         <= '0;
            low         <= '0;
            opnd        <= '0;
            is_div      <= 1'b0;
            res_sign    <= 1'b0;
            div_sign    <= 1'b0;
            dbz         <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= next_state;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        // fix_out_* hold |inA| and |inB| here
                        cnt      <= '0;
                        acc      <= '0;
                        is_div   <= op[1];
                        res_sign <= a_neg ^ b_neg;
                        div_sign <= a_neg;
                        dbz      <= op[1] & (inB == '0);
                        opnd     <= op[1] ? fix_out_lo : fix_out_hi;
                        low      <= op[1] ? fix_out_hi : fix_out_lo;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                ST_MUL: begin
                    cnt        <= cnt + 1'b1;
                    {acc, low} <= {mul_sum, low[N-1:1]};
                end
                ST_DIV: begin
                    cnt <= cnt + 1'b1;
                    if (!div_diff[N]) begin
                        acc <= div_diff[N-1:0];
                        low <= {low[N-2:0], 1'b1};
                    end else begin
                        acc <= div_shift[N-1:0];
                        low <= {low[N-2:0], 1'b0};
                    end
                end
                ST_FIX: begin
                    // A zero divisor leaves |inA| as the remainder, so the
                    // sign-fixed hi is already the original inA.
                    hi          <= fix_out_hi;
                    lo          <= dbz ? '1 : fix_out_lo;
                    done        <= 1'b1;
                    div_by_zero <= dbz;
                end
                default: ;
            endcase
        end
    end

endmodule
